// File: rtl/fg_dac_write_sequencer.sv
// fg_dac_write_sequencer: buffers generator samples and drives the DAC bus with programmable setup/write/hold/clear timing.
module fg_dac_write_sequencer #(
  parameter int BITWIDTH     = 8,
  parameter int CLR_CYCLES   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int WR_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [BITWIDTH-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic                overrun_clr_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_pd_n_o,
  output logic                dac_clr_n_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic [7:0]          drop_cnt_o
);
  localparam int MAX_SH = SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CW = CLR_CYCLES > WR_CYCLES ? CLR_CYCLES : WR_CYCLES;
  localparam int MAXC   = MAX_SH > MAX_CW ? MAX_SH : MAX_CW;
  localparam int CW     = $clog2(MAXC + 1);
  if (CLR_CYCLES < 1 || SETUP_CYCLES < 1 || WR_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("fg_dac_write_sequencer: all timing parameters must be >= 1");
  end
  typedef enum logic [2:0] {CLEAR, IDLE, SETUP, WRITE, HOLD} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] e0_q, e0_d, e1_q, e1_d, data_q, data_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic                wr_n_q, wr_n_d, pd_n_q, pd_n_d, clr_n_q, clr_n_d;
  logic                busy_q, busy_d, ovr_q, ovr_d;
  logic [7:0]          drop_q, drop_d;
  int                  lim;
  logic                last, pop, push, drop;
  assign lim  = state_q == CLEAR ? CLR_CYCLES : state_q == SETUP ? SETUP_CYCLES :
                state_q == WRITE ? WR_CYCLES : HOLD_CYCLES;
  assign last = cnt_q == CW'(lim - 1);
  assign pop  = enable_i && fcnt_q != 2'd0 && (state_q == IDLE || (state_q == HOLD && last));
  assign push = sample_valid_i && enable_i && state_q != CLEAR;
  // a full buffer still accepts a push when the head leaves on the same edge
  assign drop = push && fcnt_q == 2'd2 && !pop;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    case (state_q)
      CLEAR:   state_d = last ? IDLE : CLEAR;
      IDLE:    state_d = pop ? SETUP : IDLE;
      SETUP:   state_d = last ? WRITE : SETUP;
      WRITE:   state_d = last ? HOLD : WRITE;
      HOLD:    state_d = last ? (pop ? SETUP : IDLE) : HOLD;
      default: state_d = CLEAR;
    endcase
    if (state_q == IDLE) cnt_d = '0;
  end
  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    fcnt_d = fcnt_q;
    if (pop) begin
      e0_d   = e1_q;
      fcnt_d = fcnt_q - 2'd1;
    end
    if (push && !drop) begin
      if (fcnt_d == 2'd0) e0_d = sample_i;
      else e1_d = sample_i;
      fcnt_d = fcnt_d + 2'd1;
    end
    if (!enable_i) fcnt_d = 2'd0;
  end
  // outputs are registered from next-state so the write strobe cannot glitch
  always_comb begin
    data_d  = pop ? e0_q : data_q;
    wr_n_d  = state_d != WRITE;
    clr_n_d = state_d != CLEAR;
    pd_n_d  = enable_i && state_q != CLEAR;
    busy_d  = state_d == SETUP || state_d == WRITE || state_d == HOLD || fcnt_d != 2'd0;
    ovr_d   = drop || (ovr_q && !overrun_clr_i);
    drop_d  = drop && drop_q != 8'hff ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      data_q  <= '0;
      wr_n_q  <= 1'b1;
      pd_n_q  <= 1'b0;
      clr_n_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      data_q  <= data_d;
      wr_n_q  <= wr_n_d;
      pd_n_q  <= pd_n_d;
      clr_n_q <= clr_n_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  end
  assign dac_data_o  = data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_pd_n_o  = pd_n_q;
  assign dac_clr_n_o = clr_n_q;
  assign busy_o      = busy_q;
  assign overrun_o   = ovr_q;
  assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_fg_dac_write_sequencer.sv
// tb_fg_dac_write_sequencer: scenario tasks checked against a transaction-level model of the DAC write sequencer.
module tb_fg_dac_write_sequencer;
  localparam int CLR = 4, S = 1, W = 2, H = 1, P = S + W + H;
  logic clk = 0, rst_n = 0, en = 0, valid = 0, oclr = 0;
  logic [7:0] smp = 0;
  logic [7:0] dac_data_o, drop_cnt_o;
  logic dac_wr_n_o, dac_pd_n_o, dac_clr_n_o, busy_o, overrun_o;
  int checks = 0, errors = 0;
  // model: a FIFO of at most 2 samples feeding a writer that is occupied for P edges per pop
  logic [7:0] q[$];
  int cyc = 0, n_rel = 0, free_at = 0, wlo = -1000;
  logic [7:0] data_e = 0, drop_e = 0;
  logic ovr_e = 0, wr_e = 1, pd_e = 0, clr_e = 0, busy_e = 0;

  fg_dac_write_sequencer #(.BITWIDTH(8), .CLR_CYCLES(CLR), .SETUP_CYCLES(S), .WR_CYCLES(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .sample_i(smp), .sample_valid_i(valid),
    .overrun_clr_i(oclr), .dac_data_o(dac_data_o), .dac_wr_n_o(dac_wr_n_o), .dac_pd_n_o(dac_pd_n_o),
    .dac_clr_n_o(dac_clr_n_o), .busy_o(busy_o), .overrun_o(overrun_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    bit act, dropped;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete(); n_rel = 0; free_at = 0; wlo = -1000; data_e = '0; drop_e = '0;
      ovr_e = 0; wr_e = 1; pd_e = 0; clr_e = 0; busy_e = 0;
    end else begin
      n_rel++;
      act = n_rel > CLR;
      clr_e = n_rel >= CLR;
      dropped = 0;
      if (act && en && q.size() > 0 && cyc >= free_at) begin
        data_e = q.pop_front();
        free_at = cyc + P;
        wlo = cyc + S;
      end
      if (act && en && valid) begin
        if (q.size() < 2) q.push_back(smp);
        else begin
          dropped = 1;
          if (drop_e != 8'hff) drop_e++;
        end
      end
      ovr_e = dropped || (ovr_e && !oclr);
      if (!en) q.delete();
      pd_e = en && act;
      wr_e = !(cyc >= wlo && cyc < wlo + W);
      busy_e = cyc < free_at || q.size() != 0;
    end
    #1;
  endtask

  task automatic test_reset();
    int lowc;
    rst_n = 0; en = 1; valid = 0; oclr = 0;
    step(); step();
    checks++;
    if (dac_wr_n_o !== 1'b1 || dac_data_o !== 8'h00 || dac_pd_n_o !== 1'b0 || dac_clr_n_o !== 1'b0 ||
        busy_o !== 1'b0 || overrun_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got wr_n=%b data=%h pd_n=%b clr_n=%b busy=%b ovr=%b drops=%0d want 1 00 0 0 0 0 0",
               dac_wr_n_o, dac_data_o, dac_pd_n_o, dac_clr_n_o, busy_o, overrun_o, drop_cnt_o);
    end
    rst_n = 1;
    lowc = (dac_clr_n_o === 1'b0) ? 1 : 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (dac_clr_n_o === 1'b0) lowc++;
      checks++;
      if (dac_clr_n_o !== clr_e || dac_pd_n_o !== pd_e || dac_wr_n_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_c%0d got clr_n=%b pd_n=%b wr_n=%b want %b %b 1", i, dac_clr_n_o, dac_pd_n_o, dac_wr_n_o, clr_e, pd_e);
      end
    end
    checks++;
    if (lowc !== CLR) begin
      errors++;
      $display("FAIL clear_width got %0d cycles want %0d", lowc, CLR);
    end
  endtask

  task automatic test_single();
    en = 1; valid = 1; smp = 8'hA5;
    step();
    valid = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (dac_data_o !== 8'hA5 || dac_wr_n_o !== ((i == 2 || i == 3) ? 1'b0 : 1'b1) || busy_o !== busy_e) begin
        errors++;
        $display("FAIL single_c%0d got data=%h wr_n=%b busy=%b want A5 %b %b", i, dac_data_o, dac_wr_n_o, busy_o,
                 (i == 2 || i == 3) ? 1'b0 : 1'b1, busy_e);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end got %b want 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    int fc[$];
    logic [7:0] fd[$];
    logic pw = 1;
    en = 1;
    for (int i = 0; i < 19; i++) begin
      valid = i < 3;
      smp = i < 3 ? vals[i] : 8'h00;
      step();
      if (pw && !dac_wr_n_o) begin fc.push_back(cyc); fd.push_back(dac_data_o); end
      pw = dac_wr_n_o;
      checks++;
      if (dac_data_o !== data_e || dac_wr_n_o !== wr_e || overrun_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_c%0d got data=%h wr_n=%b ovr=%b want %h %b 0", i, dac_data_o, dac_wr_n_o, overrun_o, data_e, wr_e);
      end
    end
    valid = 0;
    checks++;
    if (fd.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 3", fd.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (fd[k] !== vals[k] || (k > 0 && fc[k] - fc[k-1] != P)) begin
          errors++;
          $display("FAIL b2b_pulse%0d got data=%h gap=%0d want %h %0d", k, fd[k], k > 0 ? fc[k] - fc[k-1] : P, vals[k], P);
        end
      end
    end
  endtask

  task automatic test_overflow();
    en = 1;
    for (int i = 0; i < 26; i++) begin
      valid = i < 8;
      smp = 8'($urandom);
      step();
      checks++;
      if (dac_data_o !== data_e || dac_wr_n_o !== wr_e || drop_cnt_o !== drop_e || overrun_o !== ovr_e) begin
        errors++;
        $display("FAIL overflow_c%0d got data=%h wr_n=%b drops=%0d ovr=%b want %h %b %0d %b", i, dac_data_o, dac_wr_n_o,
                 drop_cnt_o, overrun_o, data_e, wr_e, drop_e, ovr_e);
      end
    end
    valid = 0;
    checks++;
    if (overrun_o !== 1'b1 || drop_e == 0) begin
      errors++;
      $display("FAIL overflow_flag got ovr=%b want 1 (model drops %0d)", overrun_o, drop_e);
    end
    oclr = 1;
    step();
    oclr = 0;
    checks++;
    if (overrun_o !== 1'b0 || drop_cnt_o !== drop_e) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b drops=%0d want 0 %0d", overrun_o, drop_cnt_o, drop_e);
    end
  endtask

  task automatic test_enable_drop();
    int falls = 0;
    logic pw;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      valid = 1; smp = 8'h40 + 8'(i);
      step();
    end
    valid = 0;
    checks++;
    if (dac_wr_n_o !== 1'b0 || q.size() != 2) begin
      errors++;
      $display("FAIL endrop_setup got wr_n=%b want 0 (model buffered %0d want 2)", dac_wr_n_o, q.size());
    end
    en = 0;
    step();
    checks++;
    if (dac_pd_n_o !== 1'b0) begin
      errors++;
      $display("FAIL endrop_pd got %b want 0", dac_pd_n_o);
    end
    pw = dac_wr_n_o;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pw && !dac_wr_n_o) falls++;
      pw = dac_wr_n_o;
      checks++;
      if (dac_wr_n_o !== wr_e || dac_data_o !== data_e || dac_pd_n_o !== 1'b0) begin
        errors++;
        $display("FAIL endrop_c%0d got wr_n=%b data=%h pd_n=%b want %b %h 0", i, dac_wr_n_o, dac_data_o, dac_pd_n_o, wr_e, data_e);
      end
    end
    checks++;
    if (falls != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL endrop_after got falls=%0d busy=%b want 0 0", falls, busy_o);
    end
    en = 1;
    step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 9) != 0;
      valid = $urandom_range(0, 1) == 1;
      oclr = $urandom_range(0, 15) == 0;
      smp = 8'($urandom);
      step();
      checks++;
      if (dac_data_o !== data_e || dac_wr_n_o !== wr_e || dac_pd_n_o !== pd_e || dac_clr_n_o !== clr_e ||
          busy_o !== busy_e || overrun_o !== ovr_e || drop_cnt_o !== drop_e) begin
        errors++;
        $display("FAIL random_c%0d got data=%h wr_n=%b pd_n=%b clr_n=%b busy=%b ovr=%b drops=%0d want %h %b %b %b %b %b %0d",
                 i, dac_data_o, dac_wr_n_o, dac_pd_n_o, dac_clr_n_o, busy_o, overrun_o, drop_cnt_o,
                 data_e, wr_e, pd_e, clr_e, busy_e, ovr_e, drop_e);
      end
    end
    en = 1; valid = 0; oclr = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_reset_mid_write();
    int k = 0, lowc;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      valid = 1; smp = 8'($urandom_range(1, 255));
      step();
    end
    valid = 0;
    while (dac_wr_n_o !== 1'b0 && k < 10) begin step(); k++; end
    checks++;
    if (k >= 10) begin
      errors++;
      $display("FAIL midrst_timeout got no write pulse within %0d cycles want pulse", k);
    end
    rst_n = 0;
    step();
    checks++;
    if (dac_wr_n_o !== 1'b1 || dac_data_o !== 8'h00 || busy_o !== 1'b0 || dac_clr_n_o !== 1'b0 || dac_pd_n_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_values got wr_n=%b data=%h busy=%b clr_n=%b pd_n=%b want 1 00 0 0 0",
               dac_wr_n_o, dac_data_o, busy_o, dac_clr_n_o, dac_pd_n_o);
    end
    rst_n = 1;
    lowc = (dac_clr_n_o === 1'b0) ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (dac_clr_n_o === 1'b0) lowc++;
      checks++;
      if (dac_clr_n_o !== clr_e || dac_wr_n_o !== 1'b1 || busy_o !== 1'b0 || dac_data_o !== 8'h00) begin
        errors++;
        $display("FAIL midrst_c%0d got clr_n=%b wr_n=%b busy=%b data=%h want %b 1 0 00", i, dac_clr_n_o, dac_wr_n_o,
                 busy_o, dac_data_o, clr_e);
      end
    end
    checks++;
    if (lowc !== CLR) begin
      errors++;
      $display("FAIL midrst_clear_width got %0d want %0d", lowc, CLR);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    for (int i = 0; i < 4; i++) step();
    test_enable_drop();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fg_dac_write_sequencer.md
Name: fg_dac_write_sequencer

Overview:
- Downstream of the function generator core. Consumes its sample stream (data bus plus one-cycle valid strobe) and drives the parallel DAC bus.
- Sequences the DAC control lines with programmable setup, write-pulse and hold timing: data bus, active-low write strobe, power-down and clear.
- A 2-entry sample buffer absorbs strobes that arrive while a write is in flight; overflow is flagged and counted.

Parameters:
- BITWIDTH, 8: sample and DAC data width.
- CLR_CYCLES, 4: cycles dac_clr_n_o is held low after reset release. Must be >=1.
- SETUP_CYCLES, 1: cycles data is stable with dac_wr_n_o high before the write pulse. Must be >=1.
- WR_CYCLES, 2: width of the dac_wr_n_o low pulse, in cycles. Must be >=1; 2 cycles gives >20 ns at 50 MHz.
- HOLD_CYCLES, 1: cycles data is held after the dac_wr_n_o rising edge. Must be >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- enable_i  in  1  generator enable, already synchronized
- sample_i  in  BITWIDTH  sample from the generator
- sample_valid_i  in  1  one-cycle strobe qualifying sample_i
- overrun_clr_i  in  1  clears overrun_o
- dac_data_o  out  BITWIDTH  DAC parallel data
- dac_wr_n_o  out  1  DAC write strobe, active low
- dac_pd_n_o  out  1  DAC power-down, active low
- dac_clr_n_o  out  1  DAC clear, active low
- busy_o  out  1  write in progress or buffer non-empty
- overrun_o  out  1  sticky: a sample was dropped
- drop_cnt_o  out  8  dropped-sample count, saturating

Behaviour:
- Reset is synchronous: on any clk edge with rst_n=0, outputs take these values:
  - dac_data_o=0, dac_wr_n_o=1, dac_pd_n_o=0, dac_clr_n_o=0
  - busy_o=0, overrun_o=0, drop_cnt_o=0
  - buffer emptied, FSM=CLEAR, all timing counters=0
- Reset mid-write: dac_wr_n_o returns high on the reset edge and the pending sample is discarded.
- dac_pd_n_o is a registered copy of enable_i (one cycle latency). It is forced to 0 in CLEAR.
- FSM states: CLEAR, IDLE, SETUP, WRITE, HOLD.
  - CLEAR: dac_clr_n_o=0 for CLR_CYCLES cycles, then IDLE; dac_clr_n_o=1 in every other state. Strobes received in CLEAR are ignored and not counted.
  - IDLE: if the buffer is non-empty and enable_i=1, pop the head into dac_data_o on this edge and go to SETUP.
  - SETUP: dac_wr_n_o=1 for SETUP_CYCLES cycles, then WRITE.
  - WRITE: dac_wr_n_o=0 for WR_CYCLES cycles, then HOLD.
  - HOLD: dac_wr_n_o=1 for HOLD_CYCLES cycles. dac_data_o is unchanged throughout SETUP, WRITE and HOLD.
  - Exiting HOLD: if the buffer is non-empty and enable_i=1, pop and go directly to SETUP (back-to-back); otherwise go to IDLE.
- dac_wr_n_o is driven from a register, never combinationally; it must be glitch-free.
- Write period is SETUP_CYCLES+WR_CYCLES+HOLD_CYCLES cycles (4 with defaults).
- Latency, with the FSM in IDLE and the buffer empty:
  - Strobe in cycle t: push at edge t.
  - Pop and dac_data_o update at edge t+1.
  - dac_wr_n_o falls at edge t+1+SETUP_CYCLES and rises WR_CYCLES edges later.
- Buffer: 2-entry FIFO, push when sample_valid_i=1 and enable_i=1 and FSM != CLEAR.
  - Push while full: sample dropped, overrun_o set, drop_cnt_o incremented, saturating at 255.
  - Push and pop on the same edge while full: accepted, no drop.
  - Push while empty in IDLE: samples are never reordered; FIFO order is preserved.
- overrun_o clears on overrun_clr_i. If a drop and a clear occur on the same edge, set wins. drop_cnt_o clears only on reset.
- enable_i falling:
  - The buffer is flushed on the next edge.
  - A write already in SETUP, WRITE or HOLD completes its full timing, then the FSM goes to IDLE.
  - While enable_i=0, strobes are ignored and not counted, and IDLE does not pop.
- busy_o = (FSM in SETUP/WRITE/HOLD) OR (buffer non-empty), registered.
- Elaboration must fail (generate-time check) if any timing parameter is 0.

Test Plan:
- Reset then release, enable_i=1 -> dac_clr_n_o low exactly 4 cycles after release, dac_pd_n_o=1 one cycle after CLEAR exits, dac_wr_n_o=1 throughout.
- Single strobe of sample 0xA5 at cycle t in IDLE -> dac_data_o=0xA5 after edge t+1; dac_wr_n_o low after edges t+2 and t+3; high at edge t+4; data stable through edge t+5; busy_o drops afterwards.
- Strobes 0x11, 0x22, 0x33 on consecutive cycles -> three write pulses in order 0x11, 0x22, 0x33, spaced exactly 4 cycles apart with no IDLE gap; no overrun.
- Strobes every cycle for 8 cycles -> overrun_o=1 and drop_cnt_o equals the exact number of rejected samples (model-checked); overrun_clr_i pulse clears overrun_o; drop_cnt_o holds.
- enable_i deasserted during WRITE with 2 samples buffered -> current pulse completes full width, buffered samples discarded, dac_pd_n_o=0 one cycle after the deassertion, no further dac_wr_n_o pulses.
- rst_n asserted while dac_wr_n_o=0 -> dac_wr_n_o=1, dac_data_o=0, buffer empty after that edge, CLEAR sequence restarts on release.
